// File: rtl/bilinear_pkg.sv
// Shared types and size helpers for the bilinear core and its memory-side responder.
package bilinear_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOADED = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } frame_state_e;

    localparam int FRAC_BITS = 8;
    localparam int DEF_W_MAX = 64;
    localparam int DEF_H_MAX = 64;

    function automatic int depth_of(input int w_max, input int h_max);
        return w_max * h_max;
    endfunction

    // One extra bit so a counter can hold the full DEPTH value.
    function automatic int cnt_w_of(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bilinear_mem_responder_ram.sv
// Byte-wide LUT-style RAM with N combinational read ports and one synchronous write port.
module lut_ram_nr1w #(
    parameter int N_RD  = 4,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [N_RD-1:0][AW-1:0]  raddr,
    output logic [N_RD-1:0][DW-1:0]  rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is visible next cycle.
    generate
        for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
            assign rdata[gi] = mem[raddr[gi]];
        end
    endgenerate

endmodule

// File: rtl/bilinear_mem_responder.sv
// Memory-side responder: input image buffer with four neighbour reads, output buffer
// with host readback, and frame sequencing with status and sticky error flags.
module bilinear_mem_responder
    import bilinear_pkg::*;
#(
    parameter int W_MAX = DEF_W_MAX,
    parameter int H_MAX = DEF_H_MAX,
    parameter int DEPTH = depth_of(W_MAX, H_MAX),
    parameter int CNT_W = cnt_w_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [15:0]      in_w,
    input  logic [15:0]      in_h,
    input  logic [15:0]      out_w,
    input  logic [15:0]      out_h,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [31:0]      load_addr,
    input  logic [7:0]       load_data,
    input  logic [31:0]      rd_addr0,
    input  logic [31:0]      rd_addr1,
    input  logic [31:0]      rd_addr2,
    input  logic [31:0]      rd_addr3,
    output logic [7:0]       rd_data0,
    output logic [7:0]       rd_data1,
    output logic [7:0]       rd_data2,
    output logic [7:0]       rd_data3,
    input  logic             wr_valid,
    input  logic [31:0]      wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             rb_en,
    input  logic [31:0]      rb_addr,
    output logic [7:0]       rb_data,
    output logic             rb_valid,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] out_count,
    output logic             frame_done,
    output logic             err_rd_oob,
    output logic             err_wr_oob,
    output logic             err_seq
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] DEPTH32 = 32'(DEPTH);

    frame_state_e     state_reg, state_next;
    logic [CNT_W-1:0] load_count_reg, load_count_next;
    logic [CNT_W-1:0] out_count_reg, out_count_next;
    logic             frame_done_reg, frame_done_next;
    logic             err_rd_reg, err_rd_next;
    logic             err_wr_reg, err_wr_next;
    logic             err_seq_reg, err_seq_next;
    logic             rb_valid_reg;
    logic [7:0]       rb_data_reg;

    logic [3:0][31:0]   rd_addr_v;
    logic [3:0]         rd_oob;
    logic [3:0][AW-1:0] ib_raddr;
    logic [3:0][7:0]    ib_rdata;
    logic [0:0][AW-1:0] ob_raddr;
    logic [0:0][7:0]    ob_rdata;

    logic        load_fire, load_inb, wr_inb, rb_inb;
    logic [31:0] prod_in, prod_out, load_inc, out_inc;

    assign rd_addr_v = {rd_addr3, rd_addr2, rd_addr1, rd_addr0};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nbr
            assign rd_oob[gi]   = rd_addr_v[gi] >= DEPTH32;
            assign ib_raddr[gi] = rd_addr_v[gi][AW-1:0];
        end
    endgenerate

    assign rd_data0 = rd_oob[0] ? 8'd0 : ib_rdata[0];
    assign rd_data1 = rd_oob[1] ? 8'd0 : ib_rdata[1];
    assign rd_data2 = rd_oob[2] ? 8'd0 : ib_rdata[2];
    assign rd_data3 = rd_oob[3] ? 8'd0 : ib_rdata[3];

    assign load_ready = (state_reg == S_IDLE) || (state_reg == S_LOADED);
    assign load_fire  = load_valid && load_ready;
    assign load_inb   = load_addr < DEPTH32;
    assign wr_inb     = wr_addr < DEPTH32;
    assign rb_inb     = rb_addr < DEPTH32;
    assign ob_raddr   = rb_addr[AW-1:0];

    assign prod_in  = 32'(in_w) * 32'(in_h);
    assign prod_out = 32'(out_w) * 32'(out_h);
    assign load_inc = 32'(load_count_reg) + 32'd1;
    assign out_inc  = 32'(out_count_reg) + 32'd1;

    lut_ram_nr1w #(.N_RD(4), .DEPTH(DEPTH), .AW(AW), .DW(8)) u_in_buf (
        .clk   (clk),
        .we    (load_fire && load_inb),
        .waddr (load_addr[AW-1:0]),
        .wdata (load_data),
        .raddr (ib_raddr),
        .rdata (ib_rdata)
    );

    // Output RAM is written in every state, even when the write is flagged as out of sequence.
    lut_ram_nr1w #(.N_RD(1), .DEPTH(DEPTH), .AW(AW), .DW(8)) u_out_buf (
        .clk   (clk),
        .we    (wr_valid && wr_inb),
        .waddr (wr_addr[AW-1:0]),
        .wdata (wr_data),
        .raddr (ob_raddr),
        .rdata (ob_rdata)
    );

    always_comb begin
        state_next      = state_reg;
        load_count_next = load_count_reg;
        out_count_next  = out_count_reg;
        frame_done_next = 1'b0;
        err_rd_next     = err_rd_reg | (|rd_oob);
        err_wr_next     = err_wr_reg;
        err_seq_next    = err_seq_reg;

        if (load_fire) begin
            if (load_inb) load_count_next = load_count_reg + CNT_W'(1);
            else          err_wr_next     = 1'b1;
        end

        if (wr_valid) begin
            if (!wr_inb) err_wr_next = 1'b1;
            if (state_reg != S_DONE) out_count_next = out_count_reg + CNT_W'(1);
        end

        case (state_reg)
            S_IDLE: begin
                if (wr_valid) err_seq_next = 1'b1;
                if (load_fire && load_inb && (prod_in != 32'd0) && (load_inc == prod_in))
                    state_next = S_LOADED;
            end
            S_LOADED: begin
                if (wr_valid) begin
                    if (out_inc == prod_out) begin
                        state_next      = S_DONE;
                        frame_done_next = 1'b1;
                    end else begin
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (wr_valid && (out_inc == prod_out)) begin
                    state_next      = S_DONE;
                    frame_done_next = 1'b1;
                end
            end
            default: begin
                if (wr_valid) err_seq_next = 1'b1;
            end
        endcase

        // Clear wins over any transition or count this cycle; RAM writes above still land.
        if (clear) begin
            state_next      = S_IDLE;
            load_count_next = '0;
            out_count_next  = '0;
            frame_done_next = 1'b0;
            err_rd_next     = 1'b0;
            err_wr_next     = 1'b0;
            err_seq_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            load_count_reg <= '0;
            out_count_reg  <= '0;
            frame_done_reg <= 1'b0;
            err_rd_reg     <= 1'b0;
            err_wr_reg     <= 1'b0;
            err_seq_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            load_count_reg <= load_count_next;
            out_count_reg  <= out_count_next;
            frame_done_reg <= frame_done_next;
            err_rd_reg     <= err_rd_next;
            err_wr_reg     <= err_wr_next;
            err_seq_reg    <= err_seq_next;
        end
    end

    // Readback stage is independent of clear so an in-flight request still completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_valid_reg <= 1'b0;
            rb_data_reg  <= 8'd0;
        end else begin
            rb_valid_reg <= rb_en;
            if (rb_en) rb_data_reg <= rb_inb ? ob_rdata[0] : 8'd0;
        end
    end

    assign state      = state_reg;
    assign load_count = load_count_reg;
    assign out_count  = out_count_reg;
    assign frame_done = frame_done_reg;
    assign err_rd_oob = err_rd_reg;
    assign err_wr_oob = err_wr_reg;
    assign err_seq    = err_seq_reg;
    assign rb_valid   = rb_valid_reg;
    assign rb_data    = rb_data_reg;

endmodule
